// File: rtl/step_seq_bank_if.sv
// Per-channel control and result bundle for step_seq_bank.
// Flat NCH-wide vectors: channel i owns bit i, bits [2i+1:2i] of mode, and slice i of the data buses.
interface step_seq_bank_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       clr;
    logic [2*NCH-1:0]     mode;
    logic [NCH*WIDTH-1:0] step;
    logic [NCH*WIDTH-1:0] out;
    logic [NCH*WIDTH-1:0] aux;
    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       err;
    logic [NCH-1:0]       upd;

    modport master (
        output en, clr, mode, step,
        input  out, aux, ovf, err, upd
    );

    modport slave (
        input  en, clr, mode, step,
        output out, aux, ovf, err, upd
    );
endinterface

// File: rtl/step_seq_bank.sv
// Bank of NCH independent accumulators (hold / count-by-step / running square), one-cycle latency.
// No backpressure: every enabled edge updates; results are registered with a single-cycle upd strobe.
module step_seq_bank #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    step_seq_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_HOLD    = 2'b00,
        MODE_COUNT   = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [WIDTH-1:0] out_q, out_d;
        logic [WIDTH-1:0] aux_q, aux_d;
        logic             ovf_q, ovf_d;
        logic             err_q, err_d;
        logic             upd_q, upd_d;
        logic [WIDTH:0]   sum;
        mode_e            mode;

        assign mode = mode_e'(bus.mode[2*ch +: 2]);

        always_comb begin
            out_d = out_q;
            aux_d = aux_q;
            ovf_d = ovf_q;
            err_d = err_q;
            upd_d = 1'b0;
            sum   = '0;
            if (bus.clr[ch]) begin
                out_d = '0;
                aux_d = '0;
                ovf_d = 1'b0;
                err_d = 1'b0;
            end else if (bus.en[ch]) begin
                case (mode)
                    MODE_COUNT: begin
                        sum   = {1'b0, out_q} + {1'b0, bus.step[ch*WIDTH +: WIDTH]};
                        upd_d = 1'b1;
                    end
                    MODE_SQUARE: begin
                        // (n+1)^2 = n^2 + 2n + 1, with aux carrying 2n; aux is always even
                        sum   = {1'b0, out_q} + {1'b0, aux_q} + (WIDTH+1)'(1);
                        aux_d = aux_q + WIDTH'(2);
                        upd_d = 1'b1;
                        if (aux_q[0]) begin
                            err_d = 1'b1;
                        end
                    end
                    MODE_ILLEGAL: err_d = 1'b1;
                    default: ;
                endcase
                if (upd_d) begin
                    if (sum[WIDTH]) begin
                        ovf_d = 1'b1;
                        out_d = SATURATE ? ALL_ONES : sum[WIDTH-1:0];
                    end else begin
                        out_d = sum[WIDTH-1:0];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
                aux_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
                upd_q <= 1'b0;
            end else begin
                out_q <= out_d;
                aux_q <= aux_d;
                ovf_q <= ovf_d;
                err_q <= err_d;
                upd_q <= upd_d;
            end
        end

        assign bus.out[ch*WIDTH +: WIDTH] = out_q;
        assign bus.aux[ch*WIDTH +: WIDTH] = aux_q;
        assign bus.ovf[ch]                = ovf_q;
        assign bus.err[ch]                = err_q;
        assign bus.upd[ch]                = upd_q;
    end
endmodule

// File: tb/tb_step_seq_bank.sv
// Scoreboard bench for step_seq_bank: two 8-bit, 2-channel instances (wrap and saturate) share stimulus.
module tb_step_seq_bank;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    step_seq_bank_if #(.WIDTH(W), .NCH(2)) if0 ();
    step_seq_bank_if #(.WIDTH(W), .NCH(2)) if1 ();

    step_seq_bank #(.WIDTH(W), .NCH(2), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    step_seq_bank #(.WIDTH(W), .NCH(2), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        int         dut;
        int         ch;
        logic [7:0] out;
        logic [7:0] aux;
        logic       ovf;
        logic       err;
        logic       upd;
    } exp_t;

    exp_t sbq[$];

    function automatic void expect1(int dut, int ch, logic [7:0] o, logic [7:0] a,
                                    logic ov, logic er, logic up);
        exp_t e;
        e.tag = cyc + 1;
        e.dut = dut;
        e.ch  = ch;
        e.out = o;
        e.aux = a;
        e.ovf = ov;
        e.err = er;
        e.upd = up;
        sbq.push_back(e);
    endfunction

    function automatic void expb(int ch, logic [7:0] o, logic [7:0] a,
                                 logic ov, logic er, logic up);
        expect1(0, ch, o, a, ov, er, up);
        expect1(1, ch, o, a, ov, er, up);
    endfunction

    // ch1 parked after the overflow test: wrap instance at 88, saturating one pinned at 255
    function automatic void ch1_hold();
        expect1(0, 1, 8'd88, 8'd0, 1'b1, 1'b0, 1'b0);
        expect1(1, 1, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic drive(logic r, logic [1:0] e, logic [1:0] c, logic [3:0] m, logic [7:0] s1);
        @(negedge clk);
        rst      = r;
        if0.en   = e;
        if1.en   = e;
        if0.clr  = c;
        if1.clr  = c;
        if0.mode = m;
        if1.mode = m;
        if0.step = {s1, 8'd0};
        if1.step = {s1, 8'd0};
    endtask

    // Monitor: outputs are valid every cycle, so check every entry due this cycle
    always @(posedge clk) begin
        #2;
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            exp_t       e;
            logic [7:0] ao, aa;
            logic       av, ae, au;
            e = sbq.pop_front();
            if (e.dut == 0) begin
                ao = if0.out[e.ch*W +: W];
                aa = if0.aux[e.ch*W +: W];
                av = if0.ovf[e.ch];
                ae = if0.err[e.ch];
                au = if0.upd[e.ch];
            end else begin
                ao = if1.out[e.ch*W +: W];
                aa = if1.aux[e.ch*W +: W];
                av = if1.ovf[e.ch];
                ae = if1.err[e.ch];
                au = if1.upd[e.ch];
            end
            compared++;
            if ({ao, aa, av, ae, au} !== {e.out, e.aux, e.ovf, e.err, e.upd}) begin
                mismatched++;
                $display("FAIL cyc%0d dut%0d ch%0d: got out=%0d aux=%0d ovf=%b err=%b upd=%b, want out=%0d aux=%0d ovf=%b err=%b upd=%b",
                         cyc, e.dut, e.ch, ao, aa, av, ae, au, e.out, e.aux, e.ovf, e.err, e.upd);
            end
        end
    end

    initial begin
        int         sq_out[5] = '{1, 4, 9, 16, 25};
        int         sq_aux[5] = '{2, 4, 6, 8, 10};
        int         ct_out[5] = '{3, 3, 6, 9, 9};
        logic [4:0] ct_en     = 5'b01101;

        if0.en = '0; if0.clr = '0; if0.mode = '0; if0.step = '0;
        if1.en = '0; if1.clr = '0; if1.mode = '0; if1.step = '0;

        // reset state
        drive(1'b1, 2'b00, 2'b00, 4'b0000, 8'd0);
        expb(0, 0, 0, 0, 0, 0);
        expb(1, 0, 0, 0, 0, 0);

        // ch0 squares, ch1 counts by 3 with enable pattern 1,0,1,1,0
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, {ct_en[k], 1'b1}, 2'b00, 4'b0110, 8'd3);
            expb(0, 8'(sq_out[k]), 8'(sq_aux[k]), 0, 0, 1);
            expb(1, 8'(ct_out[k]), 0, 0, 0, ct_en[k]);
        end

        // clr beats en on ch0; ch1 keeps counting
        drive(1'b0, 2'b11, 2'b01, 4'b0110, 8'd3);
        expb(0, 0, 0, 0, 0, 0);
        expb(1, 12, 0, 0, 0, 1);

        // overflow: clear ch1 then add 200 three times
        drive(1'b0, 2'b00, 2'b10, 4'b0110, 8'd200);
        expb(0, 0, 0, 0, 0, 0);
        expb(1, 0, 0, 0, 0, 0);
        drive(1'b0, 2'b10, 2'b00, 4'b0100, 8'd200);
        expb(0, 0, 0, 0, 0, 0);
        expb(1, 200, 0, 0, 0, 1);
        drive(1'b0, 2'b10, 2'b00, 4'b0100, 8'd200);
        expb(0, 0, 0, 0, 0, 0);
        expect1(0, 1, 8'd144, 8'd0, 1'b1, 1'b0, 1'b1);
        expect1(1, 1, 8'd255, 8'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 2'b10, 2'b00, 4'b0100, 8'd200);
        expb(0, 0, 0, 0, 0, 0);
        expect1(0, 1, 8'd88, 8'd0, 1'b1, 1'b0, 1'b1);
        expect1(1, 1, 8'd255, 8'd0, 1'b1, 1'b0, 1'b1);

        // ch0 square twice; ch1 in mode 00 with en=1 holds everything
        drive(1'b0, 2'b11, 2'b00, 4'b0010, 8'd200);
        expb(0, 1, 2, 0, 0, 1);
        ch1_hold();
        drive(1'b0, 2'b11, 2'b00, 4'b0010, 8'd200);
        expb(0, 4, 4, 0, 0, 1);
        ch1_hold();

        // illegal mode: err set, out/aux held, no strobe
        drive(1'b0, 2'b11, 2'b00, 4'b0011, 8'd200);
        expb(0, 4, 4, 0, 1, 0);
        ch1_hold();

        // back to square: aux retained, err stays sticky
        drive(1'b0, 2'b11, 2'b00, 4'b0010, 8'd200);
        expb(0, 9, 6, 0, 1, 1);
        ch1_hold();

        // clr clears err
        drive(1'b0, 2'b11, 2'b01, 4'b0010, 8'd200);
        expb(0, 0, 0, 0, 0, 0);
        ch1_hold();

        // square to 9, then reset mid-sequence with en still high
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b11, 2'b00, 4'b0010, 8'd200);
            expb(0, 8'(sq_out[k]), 8'(sq_aux[k]), 0, 0, 1);
            ch1_hold();
        end
        drive(1'b1, 2'b11, 2'b00, 4'b0110, 8'd3);
        expb(0, 0, 0, 0, 0, 0);
        expb(1, 0, 0, 0, 0, 0);

        // sequence restarts after release
        drive(1'b0, 2'b11, 2'b00, 4'b0110, 8'd3);
        expb(0, 1, 2, 0, 0, 1);
        expb(1, 3, 0, 0, 0, 1);
        drive(1'b0, 2'b00, 2'b00, 4'b0110, 8'd3);
        expb(0, 1, 2, 0, 0, 0);
        expb(1, 3, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/step_seq_bank.md
STEP_SEQ_BANK -- requirements
Module: step_seq_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the bit width of each channel's accumulator and helper register.
REQ-002 The block SHALL have parameter NCH, default 2, meaning the number of independent channels.
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning overflow handling: 0 wraps modulo 2^WIDTH, 1 clamps to all-ones.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 en  input  NCH  per-channel update enable.
REQ-007 clr  input  NCH  per-channel synchronous clear.
REQ-008 mode  input  2*NCH  per-channel mode: 00 hold, 01 count, 10 square, 11 illegal. Channel i uses bits [2i+1:2i].
REQ-009 step  input  NCH*WIDTH  per-channel count increment; channel i uses slice i.
REQ-010 out  output  NCH*WIDTH  per-channel accumulator value, registered.
REQ-011 aux  output  NCH*WIDTH  per-channel square-mode helper value (2k), registered.
REQ-012 ovf  output  NCH  per-channel sticky overflow flag.
REQ-013 err  output  NCH  per-channel sticky error flag.
REQ-014 upd  output  NCH  per-channel single-cycle update strobe.

Function
REQ-015 Channels SHALL be fully independent; no channel's inputs SHALL affect another channel's outputs.
REQ-016 Per channel, priority SHALL be RST > clr > en.
REQ-017 clr=1 SHALL set out, aux, ovf, err and upd of that channel to 0 at the next edge, regardless of en and mode.
REQ-018 en=0 (and clr=0) SHALL hold out, aux, ovf and err, and SHALL drive upd=0 at the next edge.
REQ-019 Mode 00 with en=1 SHALL hold all state, with upd=0.
REQ-020 Mode 01 with en=1 SHALL set out <= out + step, leave aux unchanged, and set upd=1.
REQ-021 Mode 10 with en=1 SHALL set out <= out + 1 + aux and aux <= aux + 2 in the same edge, and SHALL set upd=1; after n such updates from clear, out = n*n and aux = 2n (absent overflow).
REQ-022 Mode 11 with en=1 SHALL hold out and aux, SHALL set err=1, and SHALL drive upd=0.
REQ-023 Sums SHALL be formed at WIDTH+1 bits; a carry out of bit WIDTH-1 SHALL set ovf=1 (sticky until clr/RST).
REQ-024 With SATURATE=0, on overflow out SHALL take the low WIDTH bits of the sum.
REQ-025 With SATURATE=1, on overflow out SHALL be set to 2^WIDTH-1, and SHALL stay there under further positive updates.
REQ-026 aux SHALL always wrap modulo 2^WIDTH, and its overflow SHALL NOT set ovf.
REQ-027 If aux[0]=1 is ever observed in mode 10 with en=1, err SHALL be set to 1; this is an integrity check and is unreachable in correct RTL.
REQ-028 A mode change SHALL take effect on the next enabled edge; aux SHALL be retained across mode changes.
REQ-029 Update latency SHALL be one cycle: inputs sampled at edge k are reflected in out/aux/upd after edge k.
REQ-030 upd SHALL be registered and aligned with the cycle in which out first shows the new value.

Reset
REQ-031 At any rising edge with RST=1, every channel's out, aux, ovf, err and upd SHALL become 0, overriding clr, en and mid-sequence state.
REQ-032 Outputs SHALL be undefined only before the first RST edge; no asynchronous reset behaviour SHALL exist.

Verification
REQ-033 RST, then ch0 mode=10, en=1 for 5 cycles -> out sequence 1,4,9,16,25; aux=10; upd=1 each cycle; ovf=0; err=0.
REQ-034 ch1 mode=01, step=3, en pattern 1,0,1,1 -> out 3,3,6,9; upd 1,0,1,1.
REQ-035 WIDTH=8, mode=01, step=200, two updates: SATURATE=0 -> out 200 then 144, ovf=1; SATURATE=1 -> out 200 then 255, ovf=1; a third update keeps 255.
REQ-036 clr=1 and en=1 in the same cycle on a channel with out=25 -> out=0, aux=0, ovf=0, upd=0 next cycle; the other channel is unaffected.
REQ-037 mode=11, en=1 -> err=1, out held, upd=0; a later mode=10 does not clear err; clr clears it.
REQ-038 RST asserted mid square sequence (out=9) -> all outputs 0 next edge; after release, the sequence restarts at 1.
